// File: rtl/hsv_pixel_sched.sv
// Pixel scheduler between the camera stream and the single rgb2hsv converter.
// Buffers tagged pixels, runs one converter transaction at a time, flags drops and hangs.
module hsv_pixel_sched #(
    parameter int FIFO_AW = 3,
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               res,
    input  logic               pix_valid,
    input  logic [15:0]        pix_data,
    input  logic               pix_sof,
    input  logic               pix_eol,
    input  logic               clr_flags,
    output logic               cv_read,
    output logic [15:0]        cv_data,
    input  logic               cv_done,
    input  logic [8:0]         cv_hue,
    input  logic [4:0]         cv_sat,
    input  logic [4:0]         cv_val,
    input  logic               cv_hue_invalid,
    output logic               out_valid,
    output logic [8:0]         out_hue,
    output logic [4:0]         out_sat,
    output logic [4:0]         out_val,
    output logic               out_hue_invalid,
    output logic [XW-1:0]      out_x,
    output logic [YW-1:0]      out_y,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               timeout
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = 16 + XW + YW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_ARM   = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]         state;
    logic [EW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [XW-1:0]      x_q;
    logic [YW-1:0]      y_q;
    logic [XW-1:0]      tag_x;
    logic [YW-1:0]      tag_y;
    logic [15:0]        hd_data;
    logic [XW-1:0]      hd_x;
    logic [YW-1:0]      hd_y;
    logic [XW-1:0]      iss_x;
    logic [YW-1:0]      iss_y;
    logic [7:0]         wcnt;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic               capture;
    logic               expire;

    assign tag_x = pix_sof ? '0 : x_q;
    assign tag_y = pix_sof ? '0 : y_q;

    assign full = (count == FULL_LVL);
    assign pop  = (state == S_IDLE) && (count != '0);
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push = pix_valid && (!full || pop);
    assign drop = pix_valid && !push;

    assign capture = (state == S_WAIT) && cv_done;
    assign expire  = (state == S_WAIT) && !cv_done
                     && (wcnt == 8'(TIMEOUT));

    assign {hd_data, hd_x, hd_y} = mem[rd_ptr];

    assign cv_read    = (state == S_ISSUE);
    assign fifo_level = count;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {pix_data, tag_x, tag_y};
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pix_valid) begin
            x_q <= pix_eol ? '0 : tag_x + XW'(1);
            y_q <= pix_eol ? tag_y + YW'(1) : tag_y;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= S_IDLE;
            cv_data <= '0;
            iss_x   <= '0;
            iss_y   <= '0;
            wcnt    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        cv_data <= hd_data;
                        iss_x   <= hd_x;
                        iss_y   <= hd_y;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_ARM;
                // Converter may still show the previous done here.
                S_ARM: begin
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture || expire)
                        state <= S_IDLE;
                    else
                        wcnt <= wcnt + 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            out_valid       <= 1'b0;
            out_hue         <= '0;
            out_sat         <= '0;
            out_val         <= '0;
            out_hue_invalid <= 1'b0;
            out_x           <= '0;
            out_y           <= '0;
        end else begin
            out_valid <= capture;
            if (capture) begin
                out_hue         <= cv_hue;
                out_sat         <= cv_sat;
                out_val         <= cv_val;
                out_hue_invalid <= cv_hue_invalid;
                out_x           <= iss_x;
                out_y           <= iss_y;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            overflow <= drop   || (overflow && !clr_flags);
            timeout  <= expire || (timeout && !clr_flags);
        end
    end

endmodule

// File: doc/hsv_pixel_sched.md
Name: hsv_pixel_sched

Overview:
Sequencer between the camera pixel stream and the single rgb2hsv converter.
- Buffers incoming RGB555-in-16-bit pixels in a small FIFO and tags each with x/y coordinates.
- Issues one-cycle read strobes to the converter and waits for its done.
- Captures HSV results and presents them, with their coordinates, to the ball-detection logic as a one-cycle result pulse.
- Camera cannot be stalled: overflow and converter hangs are flagged, not back-pressured.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (depth 8)
XW, 10, x coordinate width
YW, 9, y coordinate width
TIMEOUT, 63, max cycles in WAIT before abandoning a pixel (fits 8-bit counter)

Ports:
clk  in  1  clock; all logic on rising edge
res  in  1  reset, asynchronous, active-high
pix_valid  in  1  pixel strobe
pix_data  in  16  pixel, bits[14:0] = {r,g,b} 5 bits each, bit15 ignored
pix_sof  in  1  qualifies pix_valid: this pixel is frame start
pix_eol  in  1  qualifies pix_valid: this pixel is last of line
clr_flags  in  1  synchronous clear of sticky flags
cv_read  out  1  read strobe to converter
cv_data  out  16  pixel to converter
cv_done  in  1  converter done (level)
cv_hue  in  9  converter hue
cv_sat  in  5  converter saturation
cv_val  in  5  converter value
cv_hue_invalid  in  1  converter hue-invalid
out_valid  out  1  one-cycle result pulse
out_hue  out  9  captured hue
out_sat  out  5  captured saturation
out_val  out  5  captured value
out_hue_invalid  out  1  captured hue-invalid
out_x  out  XW  pixel x
out_y  out  YW  pixel y
fifo_level  out  FIFO_AW+1  current occupancy
overflow  out  1  sticky: pixel dropped, FIFO full
timeout  out  1  sticky: converter did not answer within TIMEOUT

Behaviour:
- Reset (async): all outputs 0; FIFO empty; x=y=0; state IDLE; timeout counter 0.
- Coordinate tagging, on every pix_valid (dropped pixels included):
  - Tag = (pix_sof ? 0 : x, pix_sof ? 0 : y).
  - Next x = pix_eol ? 0 : tag_x+1.
  - Next y = pix_eol ? tag_y+1 : tag_y.
  - x and y wrap modulo 2^XW and 2^YW.
- FIFO: entry = {pix_data, tag_x, tag_y}.
  - Push on pix_valid if not full, or if a pop occurs in the same cycle.
  - Otherwise the pixel is dropped and overflow is set.
  - fifo_level reflects the registered occupancy.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the issue register (data and tag), go to ISSUE.
  - ISSUE: cv_read=1 for exactly this cycle, cv_data = latched pixel; go to ARM. cv_data holds its value until the next ISSUE.
  - ARM: one cycle, cv_done ignored (converter clears done the cycle after read); clear timeout counter; go to WAIT.
  - WAIT:
    - If cv_done=1: capture cv_hue/sat/val/hue_invalid and the latched tag into out_* registers; out_valid=1 next cycle; go to IDLE.
    - Else, if counter == TIMEOUT: set timeout flag, discard the pixel, no out_valid, go to IDLE.
    - Else increment the counter.
- out_* data holds its value until the next capture; out_valid is high for exactly one cycle per capture.
- Latency, pixel into empty FIFO while in IDLE, sampled at edge t:
  - IDLE pops at t+1.
  - cv_read high at cycle t+2.
  - ARM at t+3; WAIT from t+4.
  - cv_done seen at cycle w gives out_valid at w+1.
- Throughput: one converter transaction at a time; no pipelining across pixels.
- clr_flags clears overflow and timeout. If a set event occurs in the same cycle, set wins.
- Simultaneous push and pop on a full FIFO: both occur, level unchanged, no overflow.

Test Plan:
- Single pixel 0x7C00 (r=31), sof=1; converter model asserts done 12 cycles after read with hue=0, sat=31, val=31 -> cv_read single pulse 2 cycles after pix_valid with cv_data=0x7C00; out_valid one pulse with hue=0, sat=31, val=31, x=0, y=0.
- Line of 4 pixels, eol on 4th, then 2 more -> out_x sequence 0,1,2,3,0,1 and out_y 0,0,0,0,1,1, results in input order.
- Burst of 10 back-to-back pixels, converter latency 12, FIFO depth 8 -> 8 buffered plus 1 popped; pixel 10 dropped, overflow=1; 9 out_valid pulses; clr_flags -> overflow=0.
- Converter model never asserts done -> timeout=1 after WAIT lasts 64 cycles; no out_valid; next queued pixel issued on the following IDLE pass.
- Converter holds done=1 from the previous pixel through ISSUE/ARM -> no capture in ARM; capture only on done seen in WAIT.
- Assert res mid-WAIT with FIFO level 3 -> immediately: cv_read=0, out_valid=0, fifo_level=0, flags 0; after release, only new pixels processed, with x=y=0.
